vision_capture_writer: RTL and testbench
========================================

Name: vision_capture_writer

Overview:
- Upstream feeder for the Qsys single-port on-chip RAM (32-bit data, 15-bit word address, 4-bit byteenable, no waitrequest, one-cycle write).
- Captures one packet of an 8-bit Avalon-ST pixel/byte stream from the vision pipeline.
- Packs bytes little-endian into 32-bit words and writes them sequentially into the RAM's Avalon-MM slave, so the Nios can read a frame snapshot from the other port.
- Software arms capture; the block waits for start-of-packet, writes until end-of-packet or the capacity limit, then reports done.

Parameters:
ADDR_W, 15, word-address width of the target RAM
BASE_ADDR, 0, first word address written
MAX_WORDS, 32768, capacity in words; BASE_ADDR+MAX_WORDS must be ≤ 2**ADDR_W
CNT_W, 16, width of word_count (must hold MAX_WORDS)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
arm  in  1  one-cycle pulse: start a new capture
abort  in  1  one-cycle pulse: cancel immediately
st_data  in  8  stream byte
st_valid  in  1  stream beat valid
st_sop  in  1  start of packet, qualified by st_valid
st_eop  in  1  end of packet, qualified by st_valid
st_ready  out  1  stream ready
mem_address  out  ADDR_W  RAM word address
mem_byteenable  out  4  lanes written
mem_chipselect  out  1  RAM select
mem_write  out  1  write strobe
mem_writedata  out  32  packed word
mem_clken  out  1  RAM clock enable, tied 1
busy  out  1  state is WAIT_SOP or CAPTURE
done  out  1  sticky: capture finished
overflow  out  1  sticky: bytes dropped at the capacity limit
word_count  out  CNT_W  words written in this capture

Behaviour:
- Clock and reset: single clock domain; reset is synchronous, active-high.
- Reset values: state IDLE; st_ready, mem_write, mem_chipselect, busy, done, overflow = 0; mem_address = BASE_ADDR; mem_byteenable = 0; mem_writedata = 0; word_count = 0; byte lane index = 0.
- States and transitions:
  - IDLE: arm → WAIT_SOP; clear done, overflow and word_count; set lane = 0 and address = BASE_ADDR.
  - WAIT_SOP: st_ready = 1. Beats without sop are consumed and discarded. An accepted beat with sop is stored as byte 0 → CAPTURE. If that beat also has eop, the block flushes and goes → DONE.
  - CAPTURE: st_ready = 1. Each accepted byte goes into lane `lane`, then lane increments.
    - Write trigger: lane==3, or eop on the beat. The assembled word and accumulated byteenable are registered onto the memory port.
    - Next cycle: mem_write = mem_chipselect = 1 for exactly one cycle. mem_address is the current word address, and it increments after the write.
    - Latency: 1 cycle from accepting the triggering byte to the write strobe.
    - Assembly and output registers are separate, so streaming continues without a stall at 1 byte/cycle.
    - A partial final word writes only the filled lanes. Example: 2 bytes → byteenable 4'b0011.
    - sop during CAPTURE is ignored; the byte is treated as data.
    - eop → DONE after its flush write issues.
  - Capacity limit: when word_count == MAX_WORDS, further bytes are accepted (st_ready stays 1) but dropped, and overflow is set. No write is issued and the address never wraps. The block still goes → DONE on eop.
  - DONE: done = 1, st_ready = 0. arm → WAIT_SOP with the same clears as from IDLE.
- word_count increments in the same cycle as each mem_write.
- abort in any state → IDLE on the next edge. Any pending flush write is cancelled: mem_write is 0 in the following cycle. done and overflow are cleared. word_count is held for debug.
- Simultaneous events: abort has priority over arm, and arm has priority over stream activity. arm in WAIT_SOP or CAPTURE is ignored.
- mem_clken is constant 1. mem_writedata and mem_byteenable are don't-care when mem_write = 0; they are held at their last value.

Decomposition:
- Shared package vision_capture_pkg:
  - state enum: IDLE, WAIT_SOP, CAPTURE, DONE
  - constants: BYTES_PER_WORD = 4, LANE_W = 2
- One natural sub-module: capture_byte_packer. It takes a byte, lane and eop, and outputs the word, byteenable and write-request registers.
- The top level holds the FSM, address/count logic and limit checking.

Test Plan:
- 8-byte packet 0x01..0x08 (sop on first beat, eop on last), BASE_ADDR 0 → writes at addr 0 data 0x04030201 BE 0xF and addr 1 data 0x08070605 BE 0xF; done=1; word_count=2; st_ready never drops.
- 6-byte packet 0xA0..0xA5 → addr 1 data 0x----A5A4 with BE 0x3; upper bytes don't-care, not written; word_count=2.
- Beats before sop (3 junk bytes), then a 1-beat packet with sop+eop data 0x5A → single write at addr 0 of 0x5A with BE 0x1; junk is never written.
- MAX_WORDS=2 with a 12-byte packet → exactly 2 writes; overflow=1; done=1 on eop; no write to addr 2.
- abort asserted on the cycle the 4th byte is accepted → no mem_write the following cycle; state IDLE; busy=0; subsequent arm and 4-byte packet writes addr BASE_ADDR.
- reset mid-CAPTURE, then arm + 4-byte packet 0x11..0x14 → clean restart; write 0x14131211 at BASE_ADDR; word_count=1.

Source files
------------

// File: rtl/vision_capture_pkg.sv
// Shared types and constants for the vision capture writer.
//   state_t        : capture FSM states
//   BYTES_PER_WORD : stream bytes packed into one RAM word
//   LANE_W         : width of the byte-lane index
package vision_capture_pkg;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned LANE_W         = 2;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_SOP,
    CAPTURE,
    DONE
  } state_t;

endpackage

// File: rtl/capture_byte_packer.sv
// Packs stream bytes little-endian into 32-bit words.
//   clk, reset : clock, synchronous active-high reset
//   cancel     : drop any partial word and any pending write request
//   accept     : byte_in is valid this cycle and goes into lane `lane`
//   byte_in    : stream byte
//   lane       : byte lane for this byte (0 = bits 7:0)
//   last       : this byte ends the packet; flush the partial word
//   word       : registered word presented to the RAM
//   byteenable : registered lane mask for word
//   wr_req     : one-cycle write request, high the cycle after the trigger
module capture_byte_packer
  import vision_capture_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              cancel,
  input  logic              accept,
  input  logic [7:0]        byte_in,
  input  logic [LANE_W-1:0] lane,
  input  logic              last,
  output logic [31:0]       word,
  output logic [3:0]        byteenable,
  output logic              wr_req
);

  // Assembly registers are separate from the output registers so a new word
  // can start filling while the previous one is being written.
  logic [31:0] asm_word;
  logic [3:0]  asm_be;
  logic [31:0] next_word;
  logic [3:0]  next_be;

  always_comb begin
    next_word = asm_word;
    next_be   = asm_be;
    for (int unsigned i = 0; i < BYTES_PER_WORD; i++) begin
      if (lane == LANE_W'(i)) begin
        next_word[8*i +: 8] = byte_in;
        next_be[i]          = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      asm_word   <= '0;
      asm_be     <= '0;
      word       <= '0;
      byteenable <= '0;
      wr_req     <= 1'b0;
    end else begin
      wr_req <= 1'b0;
      if (cancel) begin
        asm_be <= '0;
      end else if (accept) begin
        if (lane == LANE_W'(BYTES_PER_WORD - 1) || last) begin
          word       <= next_word;
          byteenable <= next_be;
          wr_req     <= 1'b1;
          asm_be     <= '0;
        end else begin
          asm_word <= next_word;
          asm_be   <= next_be;
        end
      end
    end
  end

endmodule

// File: rtl/vision_capture_writer.sv
// Captures one packet of an 8-bit Avalon-ST stream into a single-port
// on-chip RAM as little-endian 32-bit words, starting at BASE_ADDR.
//   arm / abort           : start a capture / cancel immediately (pulses)
//   st_data/valid/sop/eop : Avalon-ST sink, st_ready is the backpressure
//   mem_*                 : Avalon-MM master into the RAM (one-cycle write)
//   busy                  : waiting for sop or capturing
//   done / overflow       : sticky status, cleared by arm or abort
//   word_count            : words written in this capture
module vision_capture_writer
  import vision_capture_pkg::*;
#(
  parameter int ADDR_W    = 15,
  parameter int BASE_ADDR = 0,
  parameter int MAX_WORDS = 32768,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              arm,
  input  logic              abort,
  input  logic [7:0]        st_data,
  input  logic              st_valid,
  input  logic              st_sop,
  input  logic              st_eop,
  output logic              st_ready,
  output logic [ADDR_W-1:0] mem_address,
  output logic [3:0]        mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [31:0]       mem_writedata,
  output logic              mem_clken,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [CNT_W-1:0]  word_count
);

  localparam logic [CNT_W-1:0]  MAX_CNT    = CNT_W'(MAX_WORDS);
  localparam logic [CNT_W-1:0]  MAX_CNT_M1 = CNT_W'(MAX_WORDS - 1);
  localparam logic [ADDR_W-1:0] BASE       = ADDR_W'(BASE_ADDR);

  state_t            state;
  logic [LANE_W-1:0] lane;
  logic              accept;
  logic              full;
  logic              pack_accept;
  logic              arm_start;
  logic              pk_wr;

  assign accept = st_valid && st_ready;

  // word_count only advances at the end of a write cycle, so a write in
  // flight must count towards the limit for the byte accepted alongside it.
  assign full = (word_count == MAX_CNT) ||
                (pk_wr && (word_count == MAX_CNT_M1));

  assign pack_accept = accept && !abort &&
                       (((state == WAIT_SOP) && st_sop) ||
                        ((state == CAPTURE) && !full));

  assign arm_start = arm && !abort && ((state == IDLE) || (state == DONE));

  assign mem_clken      = 1'b1;
  assign mem_write      = pk_wr;
  assign mem_chipselect = pk_wr;

  capture_byte_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .cancel     (abort),
    .accept     (pack_accept),
    .byte_in    (st_data),
    .lane       (lane),
    .last       (st_eop),
    .word       (mem_writedata),
    .byteenable (mem_byteenable),
    .wr_req     (pk_wr)
  );

  always_ff @(posedge clk) begin
    if (reset || abort) begin
      state    <= IDLE;
      lane     <= '0;
      st_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (arm) begin
            state    <= WAIT_SOP;
            lane     <= '0;
            st_ready <= 1'b1;
            busy     <= 1'b1;
            done     <= 1'b0;
            overflow <= 1'b0;
          end
        end
        WAIT_SOP: begin
          if (accept && st_sop) begin
            lane <= LANE_W'(1);
            if (st_eop) begin
              state    <= DONE;
              st_ready <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
            end else begin
              state <= CAPTURE;
            end
          end
        end
        CAPTURE: begin
          if (accept) begin
            if (full) overflow <= 1'b1;
            else      lane     <= lane + LANE_W'(1);
            if (st_eop) begin
              state    <= DONE;
              st_ready <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Address and count are held across abort for debug; only arm restarts them.
  always_ff @(posedge clk) begin
    if (reset || arm_start) begin
      mem_address <= BASE;
      word_count  <= '0;
    end else if (pk_wr) begin
      mem_address <= mem_address + ADDR_W'(1);
      word_count  <= word_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_vision_capture_writer.sv
module tb_vision_capture_writer;

  typedef struct {
    logic [14:0] a;
    logic [31:0] d;
    logic [3:0]  be;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset, arm, abort;
  logic [7:0]  st_data;
  logic        st_valid, st_sop, st_eop;

  logic        st_ready, mem_chipselect, mem_write, mem_clken, busy, done, overflow;
  logic [14:0] mem_address;
  logic [3:0]  mem_byteenable;
  logic [31:0] mem_writedata;
  logic [15:0] word_count;

  logic        l_st_ready, l_mem_chipselect, l_mem_write, l_mem_clken, l_busy, l_done, l_overflow;
  logic [14:0] l_mem_address;
  logic [3:0]  l_mem_byteenable;
  logic [31:0] l_mem_writedata;
  logic [15:0] l_word_count;

  wr_t log_a[$];
  wr_t log_b[$];
  int  tests = 0;
  int  fails = 0;
  int  ready_drops = 0;

  always #5 clk = ~clk;

  vision_capture_writer #(.ADDR_W(15), .BASE_ADDR(0), .MAX_WORDS(32768), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .arm(arm), .abort(abort),
    .st_data(st_data), .st_valid(st_valid), .st_sop(st_sop), .st_eop(st_eop),
    .st_ready(st_ready), .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write), .mem_writedata(mem_writedata),
    .mem_clken(mem_clken), .busy(busy), .done(done), .overflow(overflow),
    .word_count(word_count)
  );

  vision_capture_writer #(.ADDR_W(15), .BASE_ADDR(0), .MAX_WORDS(2), .CNT_W(16)) dut_lim (
    .clk(clk), .reset(reset), .arm(arm), .abort(abort),
    .st_data(st_data), .st_valid(st_valid), .st_sop(st_sop), .st_eop(st_eop),
    .st_ready(l_st_ready), .mem_address(l_mem_address), .mem_byteenable(l_mem_byteenable),
    .mem_chipselect(l_mem_chipselect), .mem_write(l_mem_write), .mem_writedata(l_mem_writedata),
    .mem_clken(l_mem_clken), .busy(l_busy), .done(l_done), .overflow(l_overflow),
    .word_count(l_word_count)
  );

  // Write logger, sampled mid-cycle.
  always @(negedge clk) begin
    if (mem_write === 1'b1)
      log_a.push_back('{a: mem_address, d: mem_writedata, be: mem_byteenable});
    if (l_mem_write === 1'b1)
      log_b.push_back('{a: l_mem_address, d: l_mem_writedata, be: l_mem_byteenable});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
  endtask

  task automatic beat(input logic [7:0] d, input logic sop, input logic eop);
    if (st_ready !== 1'b1) ready_drops++;
    st_data = d; st_valid = 1'b1; st_sop = sop; st_eop = eop;
    @(negedge clk);
    st_valid = 1'b0; st_sop = 1'b0; st_eop = 1'b0;
  endtask

  // Back-to-back packet of n bytes starting at first, incrementing.
  task automatic packet(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      if (st_ready !== 1'b1) ready_drops++;
      st_data  = first + 8'(i);
      st_valid = 1'b1;
      st_sop   = (i == 0);
      st_eop   = (i == n - 1);
      @(negedge clk);
    end
    st_valid = 1'b0; st_sop = 1'b0; st_eop = 1'b0;
  endtask

  initial begin
    reset = 1'b1; arm = 1'b0; abort = 1'b0;
    st_data = '0; st_valid = 1'b0; st_sop = 1'b0; st_eop = 1'b0;
    cycles(3);
    reset = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_st_ready", {31'b0, st_ready}, 32'd0);
    check("rst_mem_write", {31'b0, mem_write}, 32'd0);
    check("rst_chipselect", {31'b0, mem_chipselect}, 32'd0);
    check("rst_address", {17'b0, mem_address}, 32'd0);
    check("rst_byteenable", {28'b0, mem_byteenable}, 32'd0);
    check("rst_writedata", mem_writedata, 32'd0);
    check("rst_busy_done_ovf", {29'b0, busy, done, overflow}, 32'd0);
    check("rst_word_count", {16'b0, word_count}, 32'd0);
    check("clken", {31'b0, mem_clken}, 32'd1);

    // 8-byte packet
    pulse_arm();
    check("t1_busy", {31'b0, busy}, 32'd1);
    ready_drops = 0;
    packet(8'h01, 8);
    cycles(3);
    check("t1_nwrites", log_a.size(), 32'd2);
    check("t1_w0_addr", {17'b0, log_a[0].a}, 32'd0);
    check("t1_w0_data", log_a[0].d, 32'h04030201);
    check("t1_w0_be", {28'b0, log_a[0].be}, 32'hF);
    check("t1_w1_addr", {17'b0, log_a[1].a}, 32'd1);
    check("t1_w1_data", log_a[1].d, 32'h08070605);
    check("t1_w1_be", {28'b0, log_a[1].be}, 32'hF);
    check("t1_done", {31'b0, done}, 32'd1);
    check("t1_busy_after", {31'b0, busy}, 32'd0);
    check("t1_word_count", {16'b0, word_count}, 32'd2);
    check("t1_ready_drops", ready_drops, 32'd0);
    check("t1_ready_in_done", {31'b0, st_ready}, 32'd0);

    // 6-byte packet, partial final word
    log_a.delete(); log_b.delete();
    pulse_arm();
    check("t2_done_cleared", {31'b0, done}, 32'd0);
    packet(8'hA0, 6);
    cycles(3);
    check("t2_nwrites", log_a.size(), 32'd2);
    check("t2_w0_data", log_a[0].d, 32'hA3A2A1A0);
    check("t2_w1_addr", {17'b0, log_a[1].a}, 32'd1);
    check("t2_w1_low", log_a[1].d & 32'h0000FFFF, 32'h0000A5A4);
    check("t2_w1_be", {28'b0, log_a[1].be}, 32'h3);
    check("t2_word_count", {16'b0, word_count}, 32'd2);

    // Junk before sop, then single-beat packet
    log_a.delete(); log_b.delete();
    pulse_arm();
    beat(8'hEE, 1'b0, 1'b0);
    beat(8'hED, 1'b0, 1'b0);
    beat(8'hEC, 1'b0, 1'b1);
    check("t3_still_waiting", {31'b0, busy}, 32'd1);
    beat(8'h5A, 1'b1, 1'b1);
    cycles(3);
    check("t3_nwrites", log_a.size(), 32'd1);
    check("t3_w0_addr", {17'b0, log_a[0].a}, 32'd0);
    check("t3_w0_low", log_a[0].d & 32'h000000FF, 32'h5A);
    check("t3_w0_be", {28'b0, log_a[0].be}, 32'h1);
    check("t3_done", {31'b0, done}, 32'd1);
    check("t3_word_count", {16'b0, word_count}, 32'd1);

    // Capacity limit (MAX_WORDS=2 instance), 12-byte packet
    log_a.delete(); log_b.delete();
    pulse_arm();
    ready_drops = 0;
    packet(8'h10, 12);
    cycles(3);
    check("t4_nwrites", log_b.size(), 32'd2);
    check("t4_w0", {log_b[0].d}, 32'h13121110);
    check("t4_w1", {log_b[1].d}, 32'h17161514);
    check("t4_w1_addr", {17'b0, log_b[1].a}, 32'd1);
    check("t4_overflow", {31'b0, l_overflow}, 32'd1);
    check("t4_done", {31'b0, l_done}, 32'd1);
    check("t4_word_count", {16'b0, l_word_count}, 32'd2);
    check("t4_addr_no_wrap", {17'b0, l_mem_address}, 32'd2);
    check("t4_ready_drops", ready_drops, 32'd0);
    check("t4_big_nwrites", log_a.size(), 32'd3);
    check("t4_big_overflow", {31'b0, overflow}, 32'd0);

    // Abort on the cycle the 4th byte is accepted
    log_a.delete(); log_b.delete();
    pulse_arm();
    beat(8'h30, 1'b1, 1'b0);
    beat(8'h31, 1'b0, 1'b0);
    beat(8'h32, 1'b0, 1'b0);
    abort = 1'b1;
    beat(8'h33, 1'b0, 1'b0);
    abort = 1'b0;
    check("t5_no_write", {31'b0, mem_write}, 32'd0);
    check("t5_busy", {31'b0, busy}, 32'd0);
    check("t5_ready", {31'b0, st_ready}, 32'd0);
    cycles(2);
    check("t5_nwrites", log_a.size(), 32'd0);
    check("t5_done", {31'b0, done}, 32'd0);
    pulse_arm();
    packet(8'h21, 4);
    cycles(3);
    check("t5_re_nwrites", log_a.size(), 32'd1);
    check("t5_re_addr", {17'b0, log_a[0].a}, 32'd0);
    check("t5_re_data", log_a[0].d, 32'h24232221);
    check("t5_re_be", {28'b0, log_a[0].be}, 32'hF);

    // Reset mid-capture, then clean restart
    log_a.delete(); log_b.delete();
    pulse_arm();
    beat(8'h40, 1'b1, 1'b0);
    beat(8'h41, 1'b0, 1'b0);
    reset = 1'b1;
    cycles(2);
    reset = 1'b0;
    check("t6_rst_busy", {31'b0, busy}, 32'd0);
    check("t6_rst_count", {16'b0, word_count}, 32'd0);
    pulse_arm();
    packet(8'h11, 4);
    cycles(3);
    check("t6_nwrites", log_a.size(), 32'd1);
    check("t6_addr", {17'b0, log_a[0].a}, 32'd0);
    check("t6_data", log_a[0].d, 32'h14131211);
    check("t6_be", {28'b0, log_a[0].be}, 32'hF);
    check("t6_word_count", {16'b0, word_count}, 32'd1);
    check("t6_done", {31'b0, done}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
